// File: rtl/mem_region_router.sv
// mem_region_router: routes one memory-request stream to NUM_TARGETS address
// regions, rebases the address into each target's local space, tracks granted
// transactions in an in-order FIFO and returns all responses, including
// internally generated decode errors, in issue order on one response port.
module mem_region_router #(
  parameter int NBIT_AXI_WIDTH  = 64,
  parameter int USER_AXI_WIDTH  = 10,
  parameter int NUM_TARGETS     = 2,
  parameter int TGT_ADDR_WIDTH  = 32,
  parameter logic [NUM_TARGETS-1:0][NBIT_AXI_WIDTH-1:0] REGION_BASE =
    {64'h0000_0000_0200_0000, 64'h0000_0000_0000_0000},
  parameter logic [NUM_TARGETS-1:0][NBIT_AXI_WIDTH-1:0] REGION_SIZE =
    {64'h0000_0000_0000_1000, 64'h0000_0000_0200_0000},
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NBIT_AXI_WIDTH-1:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     req_i,
  output logic                                     gnt_o,
  input  logic                                     we_i,
  input  logic [NBIT_AXI_WIDTH/8-1:0]              be_i,
  input  logic [NBIT_AXI_WIDTH-1:0]                addr_i,
  input  logic [NBIT_AXI_WIDTH-1:0]                wdata_i,
  input  logic [USER_AXI_WIDTH-1:0]                user_i,
  output logic                                     rvalid_o,
  output logic [NBIT_AXI_WIDTH-1:0]                rdata_o,
  output logic                                     err_o,
  output logic [NUM_TARGETS-1:0]                   tgt_req_o,
  input  logic [NUM_TARGETS-1:0]                   tgt_gnt_i,
  output logic                                     tgt_we_o,
  output logic [NBIT_AXI_WIDTH/8-1:0]              tgt_be_o,
  output logic [NUM_TARGETS*TGT_ADDR_WIDTH-1:0]    tgt_addr_o,
  output logic [NBIT_AXI_WIDTH-1:0]                tgt_wdata_o,
  output logic [USER_AXI_WIDTH-1:0]                tgt_user_o,
  input  logic [NUM_TARGETS-1:0]                   tgt_rvalid_i,
  input  logic [NUM_TARGETS*NBIT_AXI_WIDTH-1:0]    tgt_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]         outstanding_o,
  output logic                                     proto_err_o
);

  localparam int TID_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  // Region membership test; the end bound is computed one bit wider so a
  // region touching the top of the address space does not wrap.
  function automatic logic in_region(
    input logic [NBIT_AXI_WIDTH-1:0] addr,
    input logic [NBIT_AXI_WIDTH-1:0] base,
    input logic [NBIT_AXI_WIDTH-1:0] size
  );
    logic [NBIT_AXI_WIDTH:0] end_excl;
    end_excl  = {1'b0, base} + {1'b0, size};
    in_region = ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < end_excl);
  endfunction

  // Decode and tracking state
  logic [NUM_TARGETS-1:0] hit_s;
  logic                   mapped_s;
  logic [TID_W-1:0]       sel_s;
  logic                   full_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   viol_s;

  logic [TID_W-1:0]       tid_mem_r [MAX_OUTSTANDING];
  logic                   unm_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wptr_r;
  logic [PTR_W-1:0]       rptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   err_valid_r;
  logic                   proto_err_r;

  logic                   head_valid_s;
  logic [TID_W-1:0]       head_tgt_s;
  logic                   head_unm_s;
  logic [CNT_W-1:0]       remain_s;
  logic [CNT_W-1:0]       count_nxt_s;
  logic [PTR_W-1:0]       rptr_nxt_s;
  logic                   nxt_head_unm_s;

  // Shared request fields pass through unmodified
  assign tgt_we_o      = we_i;
  assign tgt_be_o      = be_i;
  assign tgt_wdata_o   = wdata_i;
  assign tgt_user_o    = user_i;
  assign outstanding_o = count_r;
  assign proto_err_o   = proto_err_r;

  assign full_s       = (count_r == CNT_W'(MAX_OUTSTANDING));
  assign head_valid_s = (count_r != {CNT_W{1'b0}});
  assign head_tgt_s   = tid_mem_r[rptr_r];
  assign head_unm_s   = unm_mem_r[rptr_r];
  assign push_s       = gnt_o;

  // Address decode: scan from the top so the lowest matching index wins
  always_comb begin
    hit_s    = '0;
    mapped_s = 1'b0;
    sel_s    = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      hit_s[k] = in_region(addr_i, REGION_BASE[k], REGION_SIZE[k]);
    end
    for (int k = NUM_TARGETS - 1; k >= 0; k--) begin
      if (hit_s[k]) begin
        mapped_s = 1'b1;
        sel_s    = TID_W'(k);
      end else begin
        mapped_s = mapped_s;
        sel_s    = sel_s;
      end
    end
  end

  // Rebase the address into every target's local space, every cycle
  always_comb begin
    logic [NBIT_AXI_WIDTH-1:0] diff;
    tgt_addr_o = '0;
    diff       = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      diff = addr_i - REGION_BASE[k];
      tgt_addr_o[k*TGT_ADDR_WIDTH +: TGT_ADDR_WIDTH] = diff[TGT_ADDR_WIDTH-1:0];
    end
  end

  // Request forwarding and upstream grant; nothing leaves while full or in reset
  always_comb begin
    tgt_req_o = '0;
    gnt_o     = 1'b0;
    if (!rst_i && req_i && !full_s) begin
      if (mapped_s) begin
        tgt_req_o[sel_s] = 1'b1;
        gnt_o            = tgt_gnt_i[sel_s];
      end else begin
        gnt_o = 1'b1;
      end
    end else begin
      tgt_req_o = '0;
      gnt_o     = 1'b0;
    end
  end

  // Response mux: mapped head returns its target's response combinationally,
  // unmapped head is answered by the error responder one cycle after becoming head
  always_comb begin
    rvalid_o = 1'b0;
    err_o    = 1'b0;
    rdata_o  = '0;
    pop_s    = 1'b0;
    if (!rst_i && head_valid_s && !head_unm_s) begin
      if (tgt_rvalid_i[head_tgt_s]) begin
        pop_s    = 1'b1;
        rvalid_o = 1'b1;
        rdata_o  = tgt_rdata_i[head_tgt_s*NBIT_AXI_WIDTH +: NBIT_AXI_WIDTH];
      end else begin
        pop_s = 1'b0;
      end
    end else if (!rst_i && head_valid_s && err_valid_r) begin
      pop_s    = 1'b1;
      rvalid_o = 1'b1;
      err_o    = 1'b1;
      rdata_o  = ERR_DATA;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Any target response not belonging to a mapped head is a protocol violation
  always_comb begin
    viol_s = 1'b0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (tgt_rvalid_i[k] &&
          !(head_valid_s && !head_unm_s && (head_tgt_s == TID_W'(k)))) begin
        viol_s = 1'b1;
      end else begin
        viol_s = viol_s;
      end
    end
  end

  // Next occupancy and the kind of entry that will sit at the head next cycle
  always_comb begin
    remain_s    = count_r - CNT_W'(pop_s);
    count_nxt_s = remain_s + CNT_W'(push_s);
    rptr_nxt_s  = rptr_r + PTR_W'(pop_s);
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      nxt_head_unm_s = 1'b0;
    end else if (remain_s == {CNT_W{1'b0}}) begin
      nxt_head_unm_s = !mapped_s;
    end else begin
      nxt_head_unm_s = unm_mem_r[rptr_nxt_s];
    end
  end

  // Tracking FIFO, error-responder arm and sticky protocol flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      err_valid_r <= 1'b0;
      proto_err_r <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tid_mem_r[i] <= '0;
        unm_mem_r[i] <= 1'b0;
      end
    end else begin
      if (push_s) begin
        tid_mem_r[wptr_r] <= sel_s;
        unm_mem_r[wptr_r] <= !mapped_s;
        wptr_r            <= wptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      rptr_r      <= rptr_nxt_s;
      count_r     <= count_nxt_s;
      err_valid_r <= nxt_head_unm_s;
      proto_err_r <= proto_err_r | viol_s;
    end
  end

endmodule

// File: tb/tb_mem_region_router.sv
// Self-checking bench for mem_region_router: directed scenarios followed by a
// randomized phase checked through a response scoreboard and a range-based
// decode model.
module tb_mem_region_router;

  localparam logic [63:0] R1_BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] R1_END  = 64'h0000_0000_0200_1000;
  localparam logic [63:0] DEAD    = 64'hDEAD_BEEF_DEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         req, gnt, we;
  logic [7:0]   be;
  logic [63:0]  addr, wdata;
  logic [9:0]   user;
  logic         rvalid, err;
  logic [63:0]  rdata;
  logic [1:0]   tgt_req, tgt_gnt, tgt_rvalid;
  logic         tgt_we;
  logic [7:0]   tgt_be;
  logic [63:0]  tgt_addr;
  logic [63:0]  tgt_wdata;
  logic [9:0]   tgt_user;
  logic [127:0] tgt_rdata;
  logic [2:0]   outstanding;
  logic         proto_err;

  typedef struct {
    bit          unm;
    int          tgt;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;
  bit   sb_en = 1'b0;

  always #5 clk = ~clk;

  mem_region_router dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .user_i(user), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .tgt_req_o(tgt_req), .tgt_gnt_i(tgt_gnt),
    .tgt_we_o(tgt_we), .tgt_be_o(tgt_be), .tgt_addr_o(tgt_addr),
    .tgt_wdata_o(tgt_wdata), .tgt_user_o(tgt_user), .tgt_rvalid_i(tgt_rvalid),
    .tgt_rdata_i(tgt_rdata), .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Region rules from the address map: [0, 32MiB) -> 0, [32MiB, 32MiB+4KiB) -> 1
  function automatic void decode(input logic [63:0] a, output bit unm, output int tgt);
    unm = 1'b0;
    tgt = 0;
    if (a < R1_BASE) tgt = 0;
    else if (a < R1_END) tgt = 1;
    else unm = 1'b1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; tgt_gnt = 2'b00; tgt_rvalid = 2'b00; tgt_rdata = '0;
  endtask

  // Scoreboard monitor: every presented response must match the oldest expectation
  always @(negedge clk) begin
    if (sb_en && rvalid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rvalid", 64'(rvalid), 64'd0);
      end else begin
        chk("sb_rdata", rdata, exp_q[0].data);
        chk("sb_err", 64'(err), 64'(exp_q[0].unm));
        void'(exp_q.pop_front());
      end
    end else if (sb_en) begin
      chk("sb_idle_rdata", {rdata[62:0], err}, 64'd0);
    end
  end

  task automatic pick_addr(output logic [63:0] a);
    logic [63:0] bnd [6];
    int kind;
    bnd[0] = 64'h0; bnd[1] = 64'h01FF_FFFF; bnd[2] = R1_BASE;
    bnd[3] = 64'h0200_0FFF; bnd[4] = R1_END; bnd[5] = 64'hFFFF_FFFF_FFFF_FFFF;
    kind = $urandom_range(0, 9);
    if (kind < 4)      a = {32'd0, $urandom} & 64'h01FF_FFFF;
    else if (kind < 7) a = R1_BASE + 64'($urandom_range(0, 4095));
    else if (kind < 8) a = {$urandom, $urandom} | 64'h0000_0001_0000_0000;
    else               a = bnd[$urandom_range(0, 5)];
  endtask

  // One randomized cycle: drive, then compare routing against the model and record grants
  task automatic rand_cycle(input bit allow_req, input bit drain);
    int          cnt, tgt;
    bit          unm, full, e_gnt;
    logic [1:0]  e_req;
    logic [63:0] a;
    exp_t        e;
    cyc();
    cnt = exp_q.size();
    pick_addr(a);
    addr    = a;
    req     = allow_req && ($urandom_range(0, 9) < 7);
    we      = 1'($urandom);
    be      = 8'($urandom);
    wdata   = {$urandom, $urandom};
    user    = 10'($urandom);
    tgt_gnt = 2'($urandom);
    tgt_rvalid = 2'b00;
    tgt_rdata  = {$urandom, $urandom, $urandom, $urandom};
    if (cnt > 0 && !exp_q[0].unm && (drain || $urandom_range(0, 1) == 1)) begin
      tgt_rvalid[exp_q[0].tgt] = 1'b1;
      tgt_rdata[exp_q[0].tgt*64 +: 64] = exp_q[0].data;
    end
    smp();
    decode(a, unm, tgt);
    full  = (cnt == 4);
    e_gnt = req && !full && (unm || tgt_gnt[tgt]);
    e_req = (req && !full && !unm) ? 2'(1 << tgt) : 2'b00;
    chk("r_gnt", 64'(gnt), 64'(e_gnt));
    chk("r_tgt_req", 64'(tgt_req), 64'(e_req));
    chk("r_outstanding", 64'(outstanding), 64'(cnt));
    chk("r_addr0", 64'(tgt_addr[31:0]), {32'd0, a[31:0]});
    chk("r_addr1", 64'(tgt_addr[63:32]), 64'(32'(a - R1_BASE)));
    chk("r_pass", {tgt_wdata ^ wdata}, 64'd0);
    chk("r_side", {45'd0, tgt_we, tgt_be, tgt_user}, {45'd0, we, be, user});
    if (e_gnt) begin
      e.unm  = unm;
      e.tgt  = tgt;
      e.data = unm ? DEAD : {$urandom, $urandom};
      exp_q.push_back(e);
    end
  endtask

  initial begin
    int guard;
    idle();
    rst = 1'b1; be = 8'hFF; wdata = '0; user = '0;
    req = 1'b1; addr = 64'h100; tgt_gnt = 2'b11;
    cyc();
    smp();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_tgt_req", 64'(tgt_req), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_proto", 64'(proto_err), 64'd0);

    // Read to target 0, response two cycles after the grant
    cyc(); rst = 1'b0; req = 1'b1; addr = 64'h100; tgt_gnt = 2'b11;
    smp();
    chk("t1_tgt_req", 64'(tgt_req), 64'd1);
    chk("t1_addr0", 64'(tgt_addr[31:0]), 64'h100);
    chk("t1_gnt", 64'(gnt), 64'd1);
    cyc(); idle();
    smp();
    chk("t1_outstanding1", 64'(outstanding), 64'd1);
    chk("t1_no_rvalid", 64'(rvalid), 64'd0);
    cyc(); tgt_rvalid = 2'b01; tgt_rdata[63:0] = 64'h1234;
    smp();
    chk("t1_rvalid", 64'(rvalid), 64'd1);
    chk("t1_rdata", rdata, 64'h1234);
    chk("t1_err", 64'(err), 64'd0);
    cyc(); idle();
    smp();
    chk("t1_outstanding0", 64'(outstanding), 64'd0);
    chk("t1_idle_rdata", rdata, 64'd0);

    // Write to target 1
    cyc(); req = 1'b1; we = 1'b1; addr = 64'h0200_0010; wdata = 64'h55; tgt_gnt = 2'b10;
    smp();
    chk("t2_tgt_req", 64'(tgt_req), 64'd2);
    chk("t2_addr1", 64'(tgt_addr[63:32]), 64'h10);
    chk("t2_we", 64'(tgt_we), 64'd1);
    chk("t2_gnt", 64'(gnt), 64'd1);
    cyc(); idle(); tgt_rvalid = 2'b10;
    smp();
    chk("t2_rvalid", 64'(rvalid), 64'd1);
    chk("t2_err", 64'(err), 64'd0);

    // Unmapped read answered by the error responder
    cyc(); idle(); req = 1'b1; addr = 64'h0300_0000;
    smp();
    chk("t3_gnt", 64'(gnt), 64'd1);
    chk("t3_tgt_req", 64'(tgt_req), 64'd0);
    chk("t3_same_cycle_rvalid", 64'(rvalid), 64'd0);
    cyc(); idle();
    smp();
    chk("t3_rvalid", 64'(rvalid), 64'd1);
    chk("t3_rdata", rdata, DEAD);
    chk("t3_err", 64'(err), 64'd1);
    cyc();
    smp();
    chk("t3_after", {62'd0, rvalid, err}, 64'd0);
    chk("t3_outstanding", 64'(outstanding), 64'd0);

    // Fill the FIFO, then check full blocking and the one-cycle unblock
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); req = 1'b1; addr = R1_BASE + 64'(i * 8); tgt_gnt = 2'b10;
      smp();
      chk("t4_fill_gnt", 64'(gnt), 64'd1);
    end
    cyc(); addr = R1_BASE + 64'h100;
    smp();
    chk("t4_full_gnt", 64'(gnt), 64'd0);
    chk("t4_full_req", 64'(tgt_req), 64'd0);
    chk("t4_full_cnt", 64'(outstanding), 64'd4);
    cyc(); tgt_rvalid = 2'b10; tgt_rdata[127:64] = 64'h77;
    smp();
    chk("t4_pop_rvalid", 64'(rvalid), 64'd1);
    chk("t4_pop_rdata", rdata, 64'h77);
    chk("t4_pop_gnt", 64'(gnt), 64'd0);
    cyc(); tgt_rvalid = 2'b00;
    smp();
    chk("t4_next_gnt", 64'(gnt), 64'd1);
    chk("t4_next_req", 64'(tgt_req), 64'd2);
    chk("t4_next_cnt", 64'(outstanding), 64'd3);
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); tgt_rvalid = 2'b10; tgt_rdata[127:64] = 64'(i);
      smp();
      chk("t4_drain_rvalid", 64'(rvalid), 64'd1);
      chk("t4_drain_rdata", rdata, 64'(i));
    end
    cyc(); idle();
    smp();
    chk("t4_empty", 64'(outstanding), 64'd0);

    // Interleaved 0,1,0 with an out-of-order target 1 response
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); req = 1'b1; tgt_gnt = 2'b11;
      addr = (i == 1) ? R1_BASE : 64'(i * 8);
      smp();
      chk("t5_gnt", 64'(gnt), 64'd1);
    end
    cyc(); idle(); tgt_rvalid = 2'b10;
    smp();
    chk("t5_drop_rvalid", 64'(rvalid), 64'd0);
    chk("t5_proto_not_yet", 64'(proto_err), 64'd0);
    cyc(); idle(); tgt_rvalid = 2'b01; tgt_rdata[63:0] = 64'hAA;
    smp();
    chk("t5_proto_set", 64'(proto_err), 64'd1);
    chk("t5_cnt", 64'(outstanding), 64'd3);
    chk("t5_r0", {rdata[62:0], rvalid}, {63'hAA, 1'b1});
    cyc(); idle(); tgt_rvalid = 2'b10; tgt_rdata[127:64] = 64'hBB;
    smp();
    chk("t5_r1", {rdata[62:0], rvalid}, {63'hBB, 1'b1});
    cyc(); idle(); tgt_rvalid = 2'b01; tgt_rdata[63:0] = 64'hCC;
    smp();
    chk("t5_r2", {rdata[62:0], rvalid}, {63'hCC, 1'b1});
    cyc(); idle();
    smp();
    chk("t5_sticky", 64'(proto_err), 64'd1);
    chk("t5_empty", 64'(outstanding), 64'd0);

    // Reset with three in flight; a late response becomes a violation
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); req = 1'b1; tgt_gnt = 2'b01; addr = 64'(i * 16);
    end
    cyc(); idle(); rst = 1'b1;
    cyc(); rst = 1'b0;
    smp();
    chk("t6_cnt", 64'(outstanding), 64'd0);
    chk("t6_proto", 64'(proto_err), 64'd0);
    cyc(); tgt_rvalid = 2'b01; tgt_rdata[63:0] = 64'h99;
    smp();
    chk("t6_late_rvalid", 64'(rvalid), 64'd0);
    cyc(); idle();
    smp();
    chk("t6_late_proto", 64'(proto_err), 64'd1);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    smp();
    chk("t6_reclear", 64'(proto_err), 64'd0);

    // Randomized traffic against the scoreboard
    sb_en = 1'b1;
    for (int i = 0; i < 1500; i++) rand_cycle(1'b1, 1'b0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      rand_cycle(1'b0, 1'b1);
      guard++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    cyc(); idle();
    smp();
    chk("final_proto", 64'(proto_err), 64'd0);
    chk("final_cnt", 64'(outstanding), 64'd0);
    sb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
